// File: rtl/adc_init_seq.sv
// Dual-ADC bring-up sequencer: waits for clock lock, resets the ADCs, kicks SPI configuration,
// issues a sync pulse and waits for both window searches to calibrate, retrying on errors.
module adc_init_seq #(
    parameter int unsigned RST_CYCLES     = 100,
    parameter int unsigned SYNC_CYCLES    = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk10m,
    input  logic       sysrst_nr0,
    input  logic       clk10m_locked,
    input  logic       a_lock,
    input  logic       b_lock,
    input  logic [4:0] a_seek_state,
    input  logic [4:0] b_seek_state,
    input  logic       a_error,
    input  logic       b_error,
    input  logic       spi_done,
    input  logic       restart,
    output logic       adc_rst_out,
    output logic       spi_start,
    output logic       adc_sync_out,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state_dbg
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RS_W  = $clog2(RST_CYCLES + 1);
    localparam int unsigned TMR_A = (TO_W > RS_W) ? TO_W : RS_W;
    localparam int unsigned TMR_W = (TMR_A > 20) ? TMR_A : 20;
    localparam int unsigned RTY_W = 4;
    localparam logic [4:0]  SEEK_CAL = 5'h15;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_ADC_RST   = 3'd2,
        S_SPI_CFG   = 3'd3,
        S_SYNC      = 3'd4,
        S_WAIT_CAL  = 3'd5,
        S_READY     = 3'd6,
        S_FAIL      = 3'd7
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               adc_rst_q, adc_rst_d;
    logic               spi_start_q, spi_start_d;
    logic               sync_q, sync_d;
    logic               ready_q, ready_d;
    logic               fail_q, fail_d;

    logic               rst_meta_q, rst_sync_q;
    logic               rst_n;
    logic [2:0]         lock_meta_q, lock_sync_q;
    logic               lock_all_c;
    logic [RTY_W-1:0]   retry_inc_c;
    logic               retry_exhaust_c;
    logic               timeout_c;

    // Reset asserts asynchronously and releases on a clock edge
    always_ff @(posedge clk10m or negedge sysrst_nr0) begin
        if (!sysrst_nr0) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    assign rst_n = rst_sync_q;

    // Lock inputs come from other clock domains
    always_ff @(posedge clk10m or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 3'b000;
            lock_sync_q <= 3'b000;
        end else begin
            lock_meta_q <= {clk10m_locked, a_lock, b_lock};
            lock_sync_q <= lock_meta_q;
        end
    end

    assign lock_all_c      = &lock_sync_q;
    assign retry_inc_c     = (retry_q == 4'hF) ? 4'hF : retry_q + RTY_W'(1);
    assign retry_exhaust_c = (32'(retry_inc_c) == MAX_RETRY);
    assign timeout_c       = (timer_q >= TMR_W'(TIMEOUT_CYCLES - 1));

    // State and registered-output flops
    always_ff @(posedge clk10m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            retry_q     <= '0;
            adc_rst_q   <= 1'b0;
            spi_start_q <= 1'b0;
            sync_q      <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            adc_rst_q   <= adc_rst_d;
            spi_start_q <= spi_start_d;
            sync_q      <= sync_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    // Next state and retry bookkeeping; lock loss outranks everything except in FAIL
    always_comb begin
        logic retry_path;
        state_d    = state_q;
        retry_d    = retry_q;
        retry_path = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (lock_all_c) state_d = S_ADC_RST;
            end
            S_ADC_RST: begin
                if (!lock_all_c)                            state_d = S_WAIT_LOCK;
                else if (timer_q == TMR_W'(RST_CYCLES - 1)) state_d = S_SPI_CFG;
            end
            S_SPI_CFG: begin
                if (!lock_all_c)    state_d = S_WAIT_LOCK;
                else if (spi_done)  state_d = S_SYNC;
                else if (timeout_c) retry_path = 1'b1;
            end
            S_SYNC: begin
                if (!lock_all_c)                             state_d = S_WAIT_LOCK;
                else if (timer_q == TMR_W'(SYNC_CYCLES - 1)) state_d = S_WAIT_CAL;
            end
            S_WAIT_CAL: begin
                if (!lock_all_c)                             state_d = S_WAIT_LOCK;
                else if (a_error || b_error || timeout_c)    retry_path = 1'b1;
                else if (a_seek_state == SEEK_CAL &&
                         b_seek_state == SEEK_CAL)           state_d = S_READY;
            end
            S_READY: begin
                if (!lock_all_c) begin
                    state_d = S_WAIT_LOCK;
                end else if (restart) begin
                    state_d = S_ADC_RST;
                    retry_d = '0;
                end
            end
            S_FAIL: begin
                if (restart) begin
                    state_d = S_ADC_RST;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (retry_path) begin
            retry_d = retry_inc_c;
            state_d = retry_exhaust_c ? S_FAIL : S_ADC_RST;
        end
    end

    // Outputs decoded from the next state so each asserts on the state's first cycle
    always_comb begin
        timer_d     = '0;
        adc_rst_d   = 1'b0;
        spi_start_d = 1'b0;
        sync_d      = 1'b0;
        ready_d     = 1'b0;
        fail_d      = 1'b0;
        if (state_d == state_q && timer_q != '1) timer_d = timer_q + TMR_W'(1);
        else if (state_d == state_q)             timer_d = timer_q;
        adc_rst_d   = (state_d == S_ADC_RST);
        spi_start_d = (state_d == S_SPI_CFG) && (state_q != S_SPI_CFG);
        sync_d      = (state_d == S_SYNC);
        ready_d     = (state_d == S_READY);
        fail_d      = (state_d == S_FAIL);
    end

    assign adc_rst_out  = adc_rst_q;
    assign spi_start    = spi_start_q;
    assign adc_sync_out = sync_q;
    assign ready        = ready_q;
    assign fail         = fail_q;
    assign retry_cnt    = retry_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_adc_init_seq.sv
// Directed bench for adc_init_seq: nominal bring-up, calibration error, lock loss,
// SPI timeout to FAIL, restart from FAIL and asynchronous reset mid-sequence.
module tb_adc_init_seq;

    localparam int SEL_RST   = 0;
    localparam int SEL_SPI   = 1;
    localparam int SEL_SYNC  = 2;
    localparam int SEL_READY = 3;
    localparam int SEL_FAIL  = 4;

    logic       clk10m = 1'b0;
    logic       sysrst_nr0 = 1'b0;
    logic       clk10m_locked = 1'b1;
    logic       a_lock = 1'b1;
    logic       b_lock = 1'b1;
    logic [4:0] a_seek_state = 5'h0;
    logic [4:0] b_seek_state = 5'h0;
    logic       a_error = 1'b0;
    logic       b_error = 1'b0;
    logic       spi_done = 1'b0;
    logic       restart = 1'b0;
    logic       adc_rst_out, spi_start, adc_sync_out, ready, fail;
    logic [3:0] retry_cnt;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;

    adc_init_seq #(
        .RST_CYCLES(100), .SYNC_CYCLES(10), .TIMEOUT_CYCLES(1000), .MAX_RETRY(3)
    ) dut (
        .clk10m(clk10m), .sysrst_nr0(sysrst_nr0), .clk10m_locked(clk10m_locked),
        .a_lock(a_lock), .b_lock(b_lock), .a_seek_state(a_seek_state),
        .b_seek_state(b_seek_state), .a_error(a_error), .b_error(b_error),
        .spi_done(spi_done), .restart(restart), .adc_rst_out(adc_rst_out),
        .spi_start(spi_start), .adc_sync_out(adc_sync_out), .ready(ready),
        .fail(fail), .retry_cnt(retry_cnt), .state_dbg(state_dbg)
    );

    always #50 clk10m = ~clk10m;

    function automatic logic sig(input int sel);
        case (sel)
            SEL_RST:   return adc_rst_out;
            SEL_SPI:   return spi_start;
            SEL_SYNC:  return adc_sync_out;
            SEL_READY: return ready;
            default:   return fail;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (sig(sel) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk10m);
        end
    endtask

    task automatic count_high(input int sel, output int n);
        n = 0;
        while (sig(sel) === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk10m);
        end
    endtask

    // Drives one attempt: answers SPI 5 cycles after spi_start, then calibrates or injects a_error
    task automatic bringup(input bit inject_err, output int rn, output int pn,
                           output int sn, output bit ok);
        bit w;
        rn = 0; pn = 0; sn = 0; ok = 1'b0;
        wait_for(SEL_RST, 3000, w);
        if (!w) return;
        count_high(SEL_RST, rn);
        pn = int'(spi_start);
        repeat (4) begin
            @(negedge clk10m);
            pn += int'(spi_start);
        end
        spi_done = 1'b1;
        @(negedge clk10m);
        spi_done = 1'b0;
        count_high(SEL_SYNC, sn);
        if (inject_err) begin
            repeat (10) @(negedge clk10m);
            a_error = 1'b1;
            @(negedge clk10m);
            a_error = 1'b0;
            ok = 1'b1;
            return;
        end
        repeat (49) @(negedge clk10m);
        a_seek_state = 5'h15;
        b_seek_state = 5'h15;
        wait_for(SEL_READY, 5, w);
        ok = w;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk10m);
        total++;
        if (state_dbg !== 3'd0) begin
            bad++; $display("FAIL rst_state: got %0d want 0", state_dbg);
        end
        total++;
        if ({adc_rst_out, spi_start, adc_sync_out, ready, fail} !== 5'b0 || retry_cnt !== 4'd0) begin
            bad++; $display("FAIL rst_outputs: got %b retry %0d want 00000 retry 0",
                            {adc_rst_out, spi_start, adc_sync_out, ready, fail}, retry_cnt);
        end
        sysrst_nr0 = 1'b1;
        @(negedge clk10m);
        total++;
        if (state_dbg !== 3'd0) begin
            bad++; $display("FAIL rst_release_sync: got %0d want 0", state_dbg);
        end
    endtask

    task automatic test_nominal();
        int rn, pn, sn;
        bit ok;
        bringup(1'b0, rn, pn, sn, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL nom_ready: ready not reached"); end
        total++;
        if (rn != 100) begin bad++; $display("FAIL nom_rst_len: got %0d want 100", rn); end
        total++;
        if (pn != 1) begin bad++; $display("FAIL nom_spi_pulses: got %0d want 1", pn); end
        total++;
        if (sn != 10) begin bad++; $display("FAIL nom_sync_len: got %0d want 10", sn); end
        total++;
        if (state_dbg !== 3'd6 || retry_cnt !== 4'd0) begin
            bad++; $display("FAIL nom_final: state %0d retry %0d want 6/0", state_dbg, retry_cnt);
        end
    endtask

    task automatic test_cal_error();
        int rn, pn, sn;
        bit ok;
        a_seek_state = 5'h0; b_seek_state = 5'h0;
        restart = 1'b1;
        @(negedge clk10m);
        restart = 1'b0;
        total++;
        if (state_dbg !== 3'd2 || adc_rst_out !== 1'b1 || ready !== 1'b0) begin
            bad++; $display("FAIL cal_restart_ready: state %0d rst %b ready %b want 2/1/0",
                            state_dbg, adc_rst_out, ready);
        end
        bringup(1'b1, rn, pn, sn, ok);
        total++;
        if (retry_cnt !== 4'd1 || state_dbg !== 3'd2 || adc_rst_out !== 1'b1) begin
            bad++; $display("FAIL cal_err_retry: retry %0d state %0d rst %b want 1/2/1",
                            retry_cnt, state_dbg, adc_rst_out);
        end
        bringup(1'b0, rn, pn, sn, ok);
        total++;
        if (!ok || rn != 100 || sn != 10 || pn != 1) begin
            bad++; $display("FAIL cal_second_try: ok %0d rst %0d spi %0d sync %0d want 1/100/1/10",
                            ok, rn, pn, sn);
        end
        total++;
        if (retry_cnt !== 4'd1 || state_dbg !== 3'd6) begin
            bad++; $display("FAIL cal_final: retry %0d state %0d want 1/6", retry_cnt, state_dbg);
        end
    endtask

    task automatic test_lock_loss();
        int rn, pn, sn, n;
        bit ok;
        b_lock = 1'b0;
        a_seek_state = 5'h0; b_seek_state = 5'h0;
        n = 0;
        while (ready === 1'b1 && n < 10) begin
            @(negedge clk10m);
            n++;
        end
        total++;
        if (n > 3) begin bad++; $display("FAIL lock_ready_drop: took %0d cycles want <=3", n); end
        repeat (20 - n) @(negedge clk10m);
        total++;
        if (state_dbg !== 3'd1 || adc_rst_out !== 1'b0) begin
            bad++; $display("FAIL lock_wait_state: state %0d rst %b want 1/0", state_dbg, adc_rst_out);
        end
        b_lock = 1'b1;
        bringup(1'b0, rn, pn, sn, ok);
        total++;
        if (!ok || rn != 100 || sn != 10 || pn != 1) begin
            bad++; $display("FAIL lock_rerun: ok %0d rst %0d spi %0d sync %0d want 1/100/1/10",
                            ok, rn, pn, sn);
        end
        total++;
        if (retry_cnt !== 4'd1) begin
            bad++; $display("FAIL lock_retry_kept: got %0d want 1", retry_cnt);
        end
    endtask

    task automatic test_timeout();
        int cyc, rises, spis;
        logic prev;
        a_seek_state = 5'h0; b_seek_state = 5'h0;
        restart = 1'b1;
        @(negedge clk10m);
        restart = 1'b0;
        total++;
        if (retry_cnt !== 4'd0 || adc_rst_out !== 1'b1) begin
            bad++; $display("FAIL to_restart: retry %0d rst %b want 0/1", retry_cnt, adc_rst_out);
        end
        cyc = 0; rises = 1; spis = 0; prev = adc_rst_out;
        while (fail !== 1'b1 && cyc < 4000) begin
            @(negedge clk10m);
            cyc++;
            if (adc_rst_out === 1'b1 && prev !== 1'b1) rises++;
            prev = adc_rst_out;
            spis += int'(spi_start);
        end
        total++;
        if (fail !== 1'b1 || state_dbg !== 3'd7 || retry_cnt !== 4'd3) begin
            bad++; $display("FAIL to_fail: fail %b state %0d retry %0d want 1/7/3",
                            fail, state_dbg, retry_cnt);
        end
        total++;
        if (rises != 3 || spis != 3) begin
            bad++; $display("FAIL to_attempts: rst %0d spi %0d want 3/3", rises, spis);
        end
        total++;
        if (cyc < 3297 || cyc > 3303) begin
            bad++; $display("FAIL to_duration: got %0d want about 3300", cyc);
        end
        clk10m_locked = 1'b0;
        repeat (10) @(negedge clk10m);
        total++;
        if (state_dbg !== 3'd7 || fail !== 1'b1) begin
            bad++; $display("FAIL to_sticky: state %0d fail %b want 7/1", state_dbg, fail);
        end
        clk10m_locked = 1'b1;
        repeat (4) @(negedge clk10m);
    endtask

    task automatic test_restart_reset();
        int rn, pn, sn;
        bit ok;
        restart = 1'b1;
        @(negedge clk10m);
        restart = 1'b0;
        total++;
        if (fail !== 1'b0 || retry_cnt !== 4'd0 || state_dbg !== 3'd2 || adc_rst_out !== 1'b1) begin
            bad++; $display("FAIL rs_restart: fail %b retry %0d state %0d rst %b want 0/0/2/1",
                            fail, retry_cnt, state_dbg, adc_rst_out);
        end
        repeat (30) @(negedge clk10m);
        #10 sysrst_nr0 = 1'b0;
        #1;
        total++;
        if (adc_rst_out !== 1'b0 || state_dbg !== 3'd0) begin
            bad++; $display("FAIL rs_async_reset: rst %b state %0d want 0/0", adc_rst_out, state_dbg);
        end
        @(negedge clk10m);
        sysrst_nr0 = 1'b1;
        bringup(1'b0, rn, pn, sn, ok);
        total++;
        if (!ok || rn != 100 || retry_cnt !== 4'd0) begin
            bad++; $display("FAIL rs_rerun: ok %0d rst %0d retry %0d want 1/100/0", ok, rn, retry_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_cal_error();
        test_lock_loss();
        test_timeout();
        test_restart_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_init_seq.md
ADC_INIT_SEQ -- requirements
Module: adc_init_seq

Interface
REQ-001 Parameter RST_CYCLES, default 100: ADC hardware-reset pulse length in clk10m cycles (10 us).
REQ-002 Parameter SYNC_CYCLES, default 10: ADC sync pulse length in clk10m cycles.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000: SPI-config and calibration timeout in clk10m cycles (100 ms).
REQ-004 Parameter MAX_RETRY, default 3: failed attempts allowed before FAIL.
REQ-005 Port clk10m, input, 1: block clock.
REQ-006 Port sysrst_nr0, input, 1: reset, asynchronous, active-low.
REQ-007 Port clk10m_locked, input, 1: system MMCM lock; asynchronous.
REQ-008 Port a_lock / b_lock, input, 1 each: ADC A/B data-clock MMCM lock; asynchronous.
REQ-009 Port a_seek_state / b_seek_state, input, 5 each: window-search state per ADC, clk10m domain; 5'h15 means calibrated.
REQ-010 Port a_error / b_error, input, 1 each: window-search error per ADC, clk10m domain.
REQ-011 Port spi_done, input, 1: SPI configuration sequence complete, single-cycle pulse, clk10m domain.
REQ-012 Port restart, input, 1: single-cycle request to rerun bring-up.
REQ-013 Port adc_rst_out, output, 1: ADC hardware reset, active-high.
REQ-014 Port spi_start, output, 1: single-cycle pulse that starts SPI configuration.
REQ-015 Port adc_sync_out, output, 1: ADC sync pulse.
REQ-016 Port ready, output, 1: both ADCs configured and calibrated.
REQ-017 Port fail, output, 1: bring-up abandoned; sticky.
REQ-018 Port retry_cnt, output, 4: failed attempts in the current run.
REQ-019 Port state_dbg, output, 3: current state encoding.

Function
REQ-020 clk10m_locked, a_lock and b_lock shall each pass through a 2-flop synchronizer; the synchronized level is lock_all = AND of all three.
REQ-021 The state encoding shall be IDLE=0, WAIT_LOCK=1, ADC_RST=2, SPI_CFG=3, SYNC=4, WAIT_CAL=5, READY=6, FAIL=7.
REQ-022 One timer (20 bits minimum) shall clear on every state entry and increment every cycle while in a state.
REQ-023 IDLE shall go to WAIT_LOCK unconditionally on the next cycle.
REQ-024 WAIT_LOCK shall go to ADC_RST on the first cycle that lock_all = 1.
REQ-025 ADC_RST shall hold adc_rst_out = 1 for exactly RST_CYCLES cycles, then go to SPI_CFG.
REQ-026 SPI_CFG shall assert spi_start on its first cycle only.
REQ-027 SPI_CFG shall go to SYNC on spi_done.
REQ-028 SPI_CFG shall take the retry path when the timer reaches TIMEOUT_CYCLES.
REQ-029 SYNC shall hold adc_sync_out = 1 for exactly SYNC_CYCLES cycles, then go to WAIT_CAL.
REQ-030 WAIT_CAL shall go to READY when a_seek_state == 5'h15 and b_seek_state == 5'h15 in the same cycle.
REQ-031 WAIT_CAL shall take the retry path on a_error, on b_error, or when the timer reaches TIMEOUT_CYCLES.
REQ-032 If error and the calibrated condition occur in the same cycle, error shall win.
REQ-033 Retry path: retry_cnt shall increment.
REQ-034 Retry path: if the new retry_cnt equals MAX_RETRY, the next state shall be FAIL; otherwise it shall be ADC_RST.
REQ-035 retry_cnt shall saturate at 15.
REQ-036 READY shall drive ready = 1 (registered, asserted on the first READY cycle).
REQ-037 In any state other than IDLE, WAIT_LOCK and FAIL, lock_all = 0 shall force WAIT_LOCK without changing retry_cnt.
REQ-038 If lock is lost in READY, ready shall deassert on the next cycle.
REQ-039 FAIL shall drive fail = 1 and remain in FAIL, ignoring lock changes, until restart.
REQ-040 restart in READY or FAIL shall clear retry_cnt and fail and go to ADC_RST.
REQ-041 restart in any other state shall be ignored.
REQ-042 Lock loss shall take priority over restart in the same cycle.
REQ-043 All outputs shall be registered; adc_rst_out, adc_sync_out and spi_start shall be decoded from the next state so that each asserts on the state's first cycle.

Reset
REQ-044 While sysrst_nr0 = 0, the state shall be IDLE, the timer and retry_cnt 0, the synchronizers 0, and all outputs 0.
REQ-045 Reset asserted mid-operation shall drop adc_rst_out, adc_sync_out and ready immediately (asynchronously).
REQ-046 Release of sysrst_nr0 shall be synchronous to clk10m.

Verification
REQ-047 Nominal bring-up: all locks high, spi_done 5 cycles after spi_start, both seek states set to 5'h15 at 50 cycles into WAIT_CAL -> adc_rst_out high 100 cycles, one spi_start pulse, adc_sync_out high 10 cycles, ready = 1, retry_cnt = 0.
REQ-048 SPI timeout (TIMEOUT_CYCLES = 1000 in the bench): spi_done never arrives -> three ADC_RST/SPI_CFG attempts, then fail = 1, retry_cnt = 3, state_dbg = 7.
REQ-049 Calibration error: a_error pulsed once in WAIT_CAL -> retry_cnt = 1, return to ADC_RST, second attempt reaches READY.
REQ-050 Lock loss: b_lock dropped for 20 cycles while READY -> ready = 0 within 3 cycles, state WAIT_LOCK, full sequence reruns, retry_cnt unchanged.
REQ-051 Restart and reset: restart pulsed in FAIL -> fail = 0, retry_cnt = 0, state ADC_RST; sysrst_nr0 asserted in the middle of ADC_RST -> adc_rst_out = 0 immediately and state_dbg = 0.
